// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The loader FSM encoding lives here so the top and the bench agree on it.
package loader_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam logic [6:0]  HALT_OPCODE = 7'b1111111;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StHold,
        StRun,
        StError
    } state_e;

    function automatic logic is_halt(input logic [31:0] word);
        return word[6:0] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
// The master is the byte source / memory side; the slave is the loader itself.
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid_o is combinational and fires
// in the same cycle the lane-3 byte is accepted, so the parent can register the write.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_data_i,
    output logic              word_valid_o,
    output logic [31:0]       word_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        word_valid_o = byte_valid_i && !clear_i && (lane_q == 2'd3);
        word_o       = {byte_data_i, shift_q};
        if (clear_i) begin
            lane_d  = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid_i) begin
            lane_d = lane_q + 2'd1;
            case (lane_q)
                2'd0:    shift_d[7:0]   = byte_data_i;
                2'd1:    shift_d[15:8]  = byte_data_i;
                2'd2:    shift_d[23:16] = byte_data_i;
                default: shift_d        = 24'd0; // lane 3 leaves through word_o
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams bytes into instruction memory while holding the core in reset,
// then releases it after the halt word. Optional checksum byte: LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    program_loader_if.slave   bus,
    output logic              cpu_rst_o,
    output logic              cpu_enable_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned   HoldW    = $clog2(RST_CYCLES + 1);
    localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(IMEM_DEPTH - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic        byte_ready;
    logic        accept;
    logic        load_start;
    logic        pack_valid;
    logic        word_valid;
    logic [31:0] word;

    assign byte_ready = (state_q == StLoad) || (state_q == StCheck);
    assign accept     = bus.byte_valid && byte_ready;
    assign pack_valid = accept && (state_q == StLoad);
    assign load_start = start_i &&
                        ((state_q == StIdle) || (state_q == StRun) || (state_q == StError));

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (load_start),
        .byte_valid_i (pack_valid),
        .byte_data_i  (bus.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (load_start) begin
            sum_d = '0;
        end else if (pack_valid) begin
            sum_d = sum_q + bus.byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wl_d    = wl_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle, StRun, StError: begin
                if (start_i) begin
                    state_d = StLoad;
                    wl_d    = '0;
                    addr_d  = '0;
                    hold_d  = '0;
                end
            end
            StLoad: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = wl_q[ADDR_W-1:0];
                    wdata_d = word;
                    wl_d    = wl_q + 1'b1;
                    hold_d  = '0;
                    if (is_halt(word)) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StHold;
`endif
                    end else if (wl_q == LastAddr) begin
                        state_d = StError;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    state_d = (BYTE_W'(sum_q + bus.byte_data) == '0) ? StHold : StError;
                end
            end
`endif
            StHold: begin
                // Counts RST_CYCLES+1 cycles so the halt write lands before release.
                if (hold_q == HoldW'(RST_CYCLES)) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wl_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wl_q    <= wl_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.byte_ready  = byte_ready;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign cpu_rst_o       = (state_q != StRun);
    assign cpu_enable_o    = (state_q == StRun);
    assign done_o          = (state_q == StRun);
    assign error_o         = (state_q == StError);
    assign words_loaded_o  = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (IMEM_DEPTH=4): expected memory writes are queued by
// the stimulus and popped by a write monitor. Also honours LOADER_CHECKSUM_EN.
module tb_program_loader;
    import loader_pkg::*;

    localparam int unsigned IMEM_DEPTH = 4;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned RST_CYCLES = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W:0]   wl;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cpu_rst;
    logic            cpu_enable;
    logic [ADDR_W:0] words_loaded;
    logic            done;
    logic            error;

    int          vectors     = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    logic [7:0]  tb_sum;
    logic        watch_en    = 1'b0;
    logic        en_seen     = 1'b0;

    program_loader_if #(.ADDR_W(ADDR_W)) bif ();

    program_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .bus            (bif.slave),
        .cpu_rst_o      (cpu_rst),
        .cpu_enable_o   (cpu_enable),
        .words_loaded_o (words_loaded),
        .done_o         (done),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    // Write monitor: every imem write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bif.imem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%0d data=%08h, no write expected",
                         bif.imem_addr, bif.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bif.imem_addr !== e.addr || bif.imem_wdata !== e.data ||
                    words_loaded !== e.wl) begin
                    miscompares++;
                    $display("FAIL imem_write got addr=%0d data=%08h wl=%0d, need addr=%0d data=%08h wl=%0d",
                             bif.imem_addr, bif.imem_wdata, words_loaded, e.addr, e.data, e.wl);
                end
            end
        end
        if (watch_en && cpu_enable) en_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got=%0h need=%0h", name, act, req);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        tb_sum = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bif.byte_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept timeout data=%02h ready=0 need=1", b);
            bif.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bif.byte_valid = 1'b0;
            tb_sum = tb_sum + b;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        exp_q.push_back('{addr: ADDR_W'(addr), data: w, wl: (ADDR_W + 1)'(addr + 1)});
    endtask

    task automatic send_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] cs;
        cs = 8'h00 - tb_sum;
        send_byte(cs, 0);
`endif
    endtask

    // Last byte was just accepted: core must stay in reset RST_CYCLES+1 cycles, then run.
    task automatic check_release(input int nw);
        for (int i = 0; i < int'(RST_CYCLES) + 1; i++) begin
            @(negedge clk);
            if (i == 0) check("ready_drop", 32'(bif.byte_ready), 32'd0);
            check("cpu_rst_hold", 32'(cpu_rst), 32'd1);
        end
        @(negedge clk);
        check("cpu_rst_release", 32'(cpu_rst), 32'd0);
        check("cpu_enable_run", 32'(cpu_enable), 32'd1);
        check("done_run", 32'(done), 32'd1);
        check("words_loaded_run", 32'(words_loaded), 32'(nw));
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        tb_sum         = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
        check("rst_imem_we", 32'(bif.imem_we), 32'd0);
        check("rst_imem_addr", 32'(bif.imem_addr), 32'd0);
        check("rst_imem_wdata", bif.imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal back-to-back load
        pulse_start();
        send_word(32'h00A00093, 0, 0);
        send_word(32'h01400113, 1, 0);
        send_word(32'h0000007F, 2, 0);
        send_checksum();
        check_release(3);

        // Reload from RUN
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        check("reload_cpu_enable", 32'(cpu_enable), 32'd0);
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_words_loaded", 32'(words_loaded), 32'd0);
        check("reload_byte_ready", 32'(bif.byte_ready), 32'd1);

        // Stalled stream: valid pattern 1-0-0-1
        send_word(32'h00A00093, 0, 2);
        send_word(32'h01400113, 1, 2);
        send_word(32'h0000007F, 2, 2);
        send_checksum();
        check_release(3);

        // Overflow: four non-halt words into a four-word memory
        @(posedge clk);
        #1;
        pulse_start();
        watch_en = 1'b1;
        for (int i = 0; i < 4; i++) send_word(32'h00000013 + 32'(i << 7), i, 0);
        @(negedge clk);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_byte_ready", 32'(bif.byte_ready), 32'd0);
        check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
        check("ovf_words_loaded", 32'(words_loaded), 32'd4);
        repeat (5) @(negedge clk);
        check("ovf_error_sticky", 32'(error), 32'd1);
        watch_en = 1'b0;
        check("ovf_enable_never", 32'(en_seen), 32'd0);

        // Reset mid-load after six bytes
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'h00000013, 0, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_byte_ready", 32'(bif.byte_ready), 32'd0);
        check("midrst_words_loaded", 32'(words_loaded), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'h0000007F, 0, 0);
        send_checksum();
        check_release(1);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum 0x81 for halt-only program, then bad checksum 0x80
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'h0000007F, 0, 0);
        send_byte(8'h81, 0);
        check_release(1);
        @(posedge clk);
        #1;
        pulse_start();
        send_word(32'h0000007F, 0, 0);
        send_byte(8'h80, 0);
        @(negedge clk);
        check("cs_bad_error", 32'(error), 32'd1);
        check("cs_bad_cpu_enable", 32'(cpu_enable), 32'd0);
        check("cs_bad_byte_ready", 32'(bif.byte_ready), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

endmodule
